// File: rtl/exp4_unidade_controle_pkg.sv
// Shared definitions for the experiment-4 control unit: state encoding (also the
// db_estado code shown on HEX5) and small state-class helpers.
package exp4_unidade_controle_pkg;

  typedef enum logic [3:0] {
    inicial       = 4'h0,
    preparacao    = 4'h1,
    espera_jogada = 4'h2,
    registra      = 4'h4,
    comparacao    = 4'h5,
    proximo       = 4'h6,
    fim_acertou   = 4'hA,
    fim_timeout   = 4'hD,
    fim_errou     = 4'hE
  } estado_t;

  function automatic logic is_fim(input estado_t e);
    return (e == fim_acertou) || (e == fim_errou) || (e == fim_timeout);
  endfunction

endpackage

// File: rtl/exp4_unidade_controle_contador_m.sv
// Modulo-M counter with synchronous clear and enable; fim flags the terminal
// count M-1. Used as the per-move timeout of the control unit.
module exp4_unidade_controle_contador_m #(
  parameter int M = 3000,
  parameter int W = (M > 2) ? $clog2(M) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  logic [W-1:0] q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (zera) begin
      q <= '0;
    end else if (conta) begin
      q <= (q == W'(M - 1)) ? '0 : q + 1'b1;
    end
  end

  assign fim = (q == W'(M - 1));

endmodule

// File: rtl/exp4_unidade_controle.sv
// Control unit for the experiment-4 game: waits for one move per memory position,
// compares it through the datapath and ends in acertou, errou or timeout.
module exp4_unidade_controle
  import exp4_unidade_controle_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 3000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       chavesIgualMemoria,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t estado_q, estado_d;
  logic    jogada_d;
  logic    jogada_borda;
  logic    fim_espera;
  logic    zera_espera;
  logic    conta_espera;

  // NOTE: async reset covers only control flops; there is no memory array to clear here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= inicial;
      jogada_d <= 1'b0;
    end else begin
      estado_q <= estado_d;
      jogada_d <= jogada;
    end
  end

  // A level held high produces a single edge, hence a single move.
  assign jogada_borda = jogada & ~jogada_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      inicial:       if (iniciar) estado_d = preparacao;
      preparacao:    estado_d = espera_jogada;
      espera_jogada: begin
        // A move arriving on the terminal-count cycle takes priority over timeout.
        if (jogada_borda)    estado_d = registra;
        else if (fim_espera) estado_d = fim_timeout;
      end
      registra:      estado_d = comparacao;
      comparacao: begin
        if (!chavesIgualMemoria) estado_d = fim_errou;
        else if (fimC)           estado_d = fim_acertou;
        else                     estado_d = proximo;
      end
      proximo:       estado_d = espera_jogada;
      fim_acertou, fim_errou, fim_timeout:
                     if (iniciar) estado_d = preparacao;
      default:       estado_d = inicial;
    endcase
  end

  always_comb begin
    zeraC     = 1'b0;
    contaC    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    case (estado_q)
      preparacao: begin
        zeraC = 1'b1;
        zeraR = 1'b1;
      end
      registra:   registraR = 1'b1;
      proximo:    contaC    = 1'b1;
      default:    ;
    endcase
  end

  assign pronto       = is_fim(estado_q);
  assign db_estado    = estado_q;
  assign conta_espera = (estado_q == espera_jogada);
  assign zera_espera  = (estado_q == preparacao) || (estado_q == registra) ||
                        (estado_q == proximo);

  // Result flags change only on state transitions, so exactly one is set in a fim state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acertou <= 1'b0;
      errou   <= 1'b0;
      timeout <= 1'b0;
    end else if (estado_d != estado_q) begin
      case (estado_d)
        preparacao: begin
          acertou <= 1'b0;
          errou   <= 1'b0;
          timeout <= 1'b0;
        end
        fim_acertou: acertou <= 1'b1;
        fim_errou:   errou   <= 1'b1;
        fim_timeout: timeout <= 1'b1;
        default:     ;
      endcase
    end
  end

  exp4_unidade_controle_contador_m #(
    .M(TIMEOUT_CICLOS)
  ) u_contador_espera (
    .clock (clock),
    .reset (reset),
    .zera  (zera_espera),
    .conta (conta_espera),
    .fim   (fim_espera)
  );

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Self-checking bench for exp4_unidade_controle with a behavioural datapath
// (16-entry memory, address counter, switch register) and an outcome scoreboard.
module tb_exp4_unidade_controle;
  import exp4_unidade_controle_pkg::*;

  localparam int TIMEOUT = 20;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       jogada;
  logic [3:0] chaves;
  logic       chavesIgualMemoria;
  logic       fimC;
  logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int n_conta = 0;
  int n_reg = 0;

  logic [3:0] mem [16];
  logic [3:0] addr;
  logic [3:0] reg_sw;
  logic [3:0] sb [$];

  wire [11:0] outs = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado};
  wire [3:0]  flags = {pronto, acertou, errou, timeout};

  always #5 clock = ~clock;

  exp4_unidade_controle #(
    .TIMEOUT_CICLOS(TIMEOUT)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .iniciar            (iniciar),
    .jogada             (jogada),
    .chavesIgualMemoria (chavesIgualMemoria),
    .fimC               (fimC),
    .zeraC              (zeraC),
    .contaC             (contaC),
    .zeraR              (zeraR),
    .registraR          (registraR),
    .pronto             (pronto),
    .acertou            (acertou),
    .errou              (errou),
    .timeout            (timeout),
    .db_estado          (db_estado)
  );

  // Datapath model driven by the control outputs.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr   <= 4'h0;
      reg_sw <= 4'h0;
    end else begin
      if (zeraC)       addr <= 4'h0;
      else if (contaC) addr <= addr + 4'h1;
      if (zeraR)          reg_sw <= 4'h0;
      else if (registraR) reg_sw <= chaves;
    end
  end

  assign chavesIgualMemoria = (reg_sw == mem[addr]);
  assign fimC               = (addr == 4'hF);

  always @(posedge clock) begin
    if (contaC)    n_conta <= n_conta + 1;
    if (registraR) n_reg   <= n_reg + 1;
  end

  // Scoreboard consumer: each entry into proximo or a fim state pops one expectation.
  initial begin : monitor
    logic [3:0] prev;
    logic [3:0] exp_code;
    prev = 4'h0;
    forever begin
      @(negedge clock);
      if (reset && db_estado != prev &&
          (db_estado == proximo || db_estado == fim_acertou ||
           db_estado == fim_errou || db_estado == fim_timeout)) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL outcome: entered state %h with no outcome expected", db_estado);
        end else begin
          exp_code = sb.pop_front();
          if (db_estado !== exp_code) begin
            errors++;
            $display("FAIL outcome: state %h, expected %h", db_estado, exp_code);
          end
        end
      end
      prev = db_estado;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_state(input logic [3:0] code, input int budget, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clock);
      if (db_estado === code) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: state %h not reached in %0d cycles, got %h", name, code, budget, db_estado);
    end
  endtask

  task automatic start_round(input string name);
    @(negedge clock);
    iniciar = 1'b1;
    @(negedge clock);
    checks++;
    if (outs !== {1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'h1}) begin
      errors++;
      $display("FAIL %s_prep: outputs %b, expected %b", name, outs, {1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'h1});
    end
    iniciar = 1'b0;
    @(negedge clock);
    checks++;
    if (outs !== {8'b0, 4'h2}) begin
      errors++;
      $display("FAIL %s_espera: outputs %b, expected %b", name, outs, {8'b0, 4'h2});
    end
  endtask

  task automatic play_move(input logic [3:0] sw, input logic [3:0] expect_code, input string name);
    wait_state(espera_jogada, 40, name);
    chaves = sw;
    sb.push_back(expect_code);
    jogada = 1'b1;
    @(negedge clock);
    checks++;
    if (db_estado !== registra || registraR !== 1'b1) begin
      errors++;
      $display("FAIL %s_registra: state %h registraR %b, expected 4 and 1", name, db_estado, registraR);
    end
    jogada = 1'b0;
    @(negedge clock);
    // Switches are already captured; changing them now must not matter.
    chaves = ~sw;
    checks++;
    if (outs[11:8] !== 4'b0 || db_estado !== comparacao) begin
      errors++;
      $display("FAIL %s_compara: controls %b state %h, expected 0000 and 5", name, outs[11:8], db_estado);
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0; iniciar = 1'b0; jogada = 1'b0; chaves = 4'h0;
    repeat (3) @(negedge clock);
    checks++;
    if (outs !== 12'b0) begin
      errors++;
      $display("FAIL reset: outputs %b, expected all 0", outs);
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (outs !== 12'b0) begin
      errors++;
      $display("FAIL idle: outputs %b, expected all 0 without iniciar", outs);
    end
  endtask

  task automatic test_all_correct();
    int base;
    start_round("start");
    base = n_conta;
    for (int i = 0; i < 16; i++)
      play_move(mem[i], (i == 15) ? 4'hA : 4'h6, "acerto");
    @(negedge clock);
    // The last correct move ends the round instead of advancing the counter.
    checks++;
    if (n_conta - base !== 15) begin
      errors++;
      $display("FAIL acerto_contaC: pulses %0d, expected 15", n_conta - base);
    end
    checks++;
    if (db_estado !== 4'hA || flags !== 4'b1100) begin
      errors++;
      $display("FAIL acerto_end: state %h flags %b, expected A and 1100", db_estado, flags);
    end
  endtask

  task automatic test_wrong_move();
    int base;
    start_round("restart_a");
    base = n_conta;
    for (int i = 0; i < 3; i++) play_move(mem[i], 4'h6, "erro_ok");
    play_move(mem[3] ^ 4'h5, 4'hE, "erro_bad");
    @(negedge clock);
    checks++;
    if (n_conta - base !== 3) begin
      errors++;
      $display("FAIL erro_contaC: pulses %0d, expected 3", n_conta - base);
    end
    checks++;
    if (db_estado !== 4'hE || flags !== 4'b1010) begin
      errors++;
      $display("FAIL erro_end: state %h flags %b, expected E and 1010", db_estado, flags);
    end
  endtask

  task automatic test_restart_from_errou();
    @(negedge clock);
    iniciar = 1'b1;
    @(negedge clock);
    checks++;
    if (db_estado !== 4'h1 || flags !== 4'b0000) begin
      errors++;
      $display("FAIL restart_prep: state %h flags %b, expected 1 and 0000", db_estado, flags);
    end
    @(negedge clock);
    checks++;
    if (db_estado !== 4'h2) begin
      errors++;
      $display("FAIL iniciar_prep_ignored: state %h, expected 2", db_estado);
    end
    @(negedge clock);
    checks++;
    if (db_estado !== 4'h2) begin
      errors++;
      $display("FAIL iniciar_espera_ignored: state %h, expected 2", db_estado);
    end
    iniciar = 1'b0;
  endtask

  task automatic test_timeout();
    sb.push_back(4'hD);
    wait_state(fim_timeout, 40, "timeout_free");
    checks++;
    if (flags !== 4'b1001) begin
      errors++;
      $display("FAIL timeout_flags: flags %b, expected 1001", flags);
    end
    start_round("restart_d");
    sb.push_back(4'hD);
    repeat (TIMEOUT - 1) @(negedge clock);
    checks++;
    if (db_estado !== 4'h2) begin
      errors++;
      $display("FAIL timeout_cycle19: state %h, expected 2", db_estado);
    end
    @(negedge clock);
    checks++;
    if (db_estado !== 4'hD || timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_cycle20: state %h timeout %b, expected D and 1", db_estado, timeout);
    end
  endtask

  task automatic test_edge_on_terminal();
    start_round("restart_edge");
    repeat (TIMEOUT - 1) @(negedge clock);
    chaves = mem[0];
    sb.push_back(4'h6);
    jogada = 1'b1;
    @(negedge clock);
    checks++;
    if (db_estado !== 4'h4) begin
      errors++;
      $display("FAIL edge_vs_timeout: state %h, expected 4", db_estado);
    end
    jogada = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_held_jogada();
    int base;
    wait_state(espera_jogada, 40, "held_wait");
    base = n_reg;
    chaves = mem[1];
    sb.push_back(4'h6);
    sb.push_back(4'hD);
    jogada = 1'b1;
    repeat (50) @(negedge clock);
    jogada = 1'b0;
    checks++;
    if (n_reg - base !== 1) begin
      errors++;
      $display("FAIL held_registraR: pulses %0d, expected 1", n_reg - base);
    end
    checks++;
    if (db_estado !== 4'hD) begin
      errors++;
      $display("FAIL held_end: state %h, expected D", db_estado);
    end
  endtask

  task automatic test_reset_mid_round();
    start_round("restart_abort");
    chaves = mem[0];
    jogada = 1'b1;
    @(negedge clock);
    jogada = 1'b0;
    @(negedge clock);
    checks++;
    if (db_estado !== 4'h5) begin
      errors++;
      $display("FAIL abort_setup: state %h, expected 5", db_estado);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (outs !== 12'b0) begin
      errors++;
      $display("FAIL abort_async: outputs %b, expected all 0", outs);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (outs !== 12'b0) begin
      errors++;
      $display("FAIL abort_after: outputs %b, expected all 0", outs);
    end
  endtask

  initial begin : main
    for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(0, 15));
    test_reset();
    test_all_correct();
    test_wrong_move();
    test_restart_from_errou();
    test_timeout();
    test_edge_on_terminal();
    test_held_jogada();
    test_reset_mid_round();
    @(negedge clock);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d outcomes pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
